// File: rtl/branch_pkg.sv
// branch_pkg: condition codes, branch types and NZCV bit positions shared by the branch unit.
package branch_pkg;
  typedef enum logic [3:0] {EQ, NE, HS, LO, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL, NV} cond_t;
  typedef enum logic [1:0] {BR_B, BR_COND, BR_CBZ, BR_CBNZ} br_type_t;
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;
endpackage

// File: rtl/flag_branch_unit_if.sv
// flag_branch_unit_if: ALU flags, branch request/control and registered decision bundle.
interface flag_branch_unit_if;
  logic       alu_negative;
  logic       alu_zero;
  logic       alu_overflow;
  logic       alu_carry_out;
  logic       set_flags;
  logic       br_req;
  logic [1:0] br_type;
  logic [3:0] cond;
  logic       stall;
  logic       flush;
  logic [3:0] flags;
  logic       br_valid;
  logic       br_taken;
  modport master (output alu_negative, alu_zero, alu_overflow, alu_carry_out, set_flags, br_req,
                  br_type, cond, stall, flush, input flags, br_valid, br_taken);
  modport slave  (input alu_negative, alu_zero, alu_overflow, alu_carry_out, set_flags, br_req,
                  br_type, cond, stall, flush, output flags, br_valid, br_taken);
endinterface

// File: rtl/cond_eval.sv
// cond_eval: combinational LEGv8 B.cond evaluation against {N,Z,C,V}.
module cond_eval
  import branch_pkg::*;
(
  input  logic [3:0] i_cond,
  input  logic [3:0] i_flags,
  output logic       o_pass
);
  logic w_n, w_z, w_c, w_v, w_base;
  assign w_n = i_flags[FLAG_N];
  assign w_z = i_flags[FLAG_Z];
  assign w_c = i_flags[FLAG_C];
  assign w_v = i_flags[FLAG_V];
  // even codes test the base condition, odd codes its inverse; AL/NV always pass
  always_comb begin
    w_base = i_cond[3:1] == 3'd0 ? w_z :
             i_cond[3:1] == 3'd1 ? w_c :
             i_cond[3:1] == 3'd2 ? w_n :
             i_cond[3:1] == 3'd3 ? w_v :
             i_cond[3:1] == 3'd4 ? (w_c & ~w_z) :
             i_cond[3:1] == 3'd5 ? (w_n == w_v) :
             i_cond[3:1] == 3'd6 ? (~w_z & (w_n == w_v)) : 1'b1;
    o_pass = (&i_cond[3:1]) ? 1'b1 : (w_base ^ i_cond[0]);
  end
endmodule

// File: rtl/flag_branch_unit.sv
// flag_branch_unit: NZCV flag register plus registered branch decision for B, B.cond, CBZ, CBNZ.
module flag_branch_unit
  import branch_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  flag_branch_unit_if.slave bus
);
  logic [3:0] r_flags;
  logic       r_valid, r_taken;
  logic [3:0] w_alu_flags, w_eff_flags;
  logic       w_pass, w_dec;
  assign w_alu_flags = {bus.alu_negative, bus.alu_zero, bus.alu_carry_out, bus.alu_overflow};
  // a flag-setting instruction in the same cycle feeds its flags straight to B.cond
  assign w_eff_flags = bus.set_flags ? w_alu_flags : r_flags;
  cond_eval u_cond_eval (.i_cond(bus.cond), .i_flags(w_eff_flags), .o_pass(w_pass));
  always_comb begin
    w_dec = bus.br_type == BR_B    ? 1'b1 :
            bus.br_type == BR_COND ? w_pass :
            bus.br_type == BR_CBZ  ? bus.alu_zero : ~bus.alu_zero;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flags <= '0;
      r_valid <= 1'b0;
      r_taken <= 1'b0;
    end else if (!bus.stall) begin
      if (bus.flush) begin
        r_valid <= 1'b0;
        r_taken <= 1'b0;
      end else begin
        if (bus.set_flags) r_flags <= w_alu_flags;
        r_valid <= bus.br_req;
        r_taken <= bus.br_req & w_dec;
      end
    end
  end
  assign bus.flags    = r_flags;
  assign bus.br_valid = r_valid;
  assign bus.br_taken = r_taken;
endmodule

// File: tb/tb_flag_branch_unit.sv
// tb_flag_branch_unit: directed + random stimulus with a queued reference model and a decoupled monitor.
module tb_flag_branch_unit;
  import branch_pkg::*;
  logic clk = 1'b0;
  logic reset;
  int total = 0;
  int bad = 0;
  logic [3:0] m_flags = '0;
  logic       m_valid = 1'b0;
  logic       m_taken = 1'b0;
  logic [5:0] exp_q[$];
  flag_branch_unit_if bus ();
  flag_branch_unit dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  function automatic bit cond_pass(input logic [3:0] cc, input logic [3:0] f);
    bit n, z, c, v;
    {n, z, c, v} = f;
    case (cond_t'(cc))
      EQ: return z;
      NE: return !z;
      HS: return c;
      LO: return !c;
      MI: return n;
      PL: return !n;
      VS: return v;
      VC: return !v;
      HI: return c && !z;
      LS: return !(c && !z);
      GE: return n == v;
      LT: return n != v;
      GT: return !z && n == v;
      LE: return !(!z && n == v);
      default: return 1'b1;
    endcase
  endfunction
  task automatic drive(input logic sf, input logic [3:0] a, input logic req, input logic [1:0] t,
                       input logic [3:0] cc, input logic st, input logic fl);
    bit dec;
    logic [3:0] eff;
    @(negedge clk);
    bus.set_flags = sf;
    {bus.alu_negative, bus.alu_zero, bus.alu_carry_out, bus.alu_overflow} = a;
    bus.br_req = req;
    bus.br_type = t;
    bus.cond = cc;
    bus.stall = st;
    bus.flush = fl;
    if (!st) begin
      if (fl) begin
        m_valid = 1'b0;
        m_taken = 1'b0;
      end else begin
        eff = sf ? a : m_flags;
        case (br_type_t'(t))
          BR_B:    dec = 1'b1;
          BR_COND: dec = cond_pass(cc, eff);
          BR_CBZ:  dec = a[2];
          default: dec = !a[2];
        endcase
        m_valid = req;
        m_taken = req && dec;
        if (sf) m_flags = a;
      end
    end
    exp_q.push_back({m_flags, m_valid, m_taken});
  endtask
  task automatic check(input string name, input logic [5:0] act, input logic [5:0] req_v);
    total++;
    if (act !== req_v) begin
      bad++;
      $display("FAIL %s: got flags=%b valid=%b taken=%b, want flags=%b valid=%b taken=%b",
               name, act[5:2], act[1], act[0], req_v[5:2], req_v[1], req_v[0]);
    end
  endtask
  initial begin
    logic [5:0] e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("scoreboard", {bus.flags, bus.br_valid, bus.br_taken}, e);
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want finish before 200000");
    $fatal(1);
  end
  initial begin
    reset = 1'b1;
    bus.set_flags = 0; bus.alu_negative = 0; bus.alu_zero = 0; bus.alu_carry_out = 0;
    bus.alu_overflow = 0; bus.br_req = 0; bus.br_type = 0; bus.cond = 0; bus.stall = 0; bus.flush = 0;
    #3;
    check("reset_state", {bus.flags, bus.br_valid, bus.br_taken}, 6'b0);
    @(negedge clk);
    reset = 1'b0;
    // flag write then B.cond EQ / NE against registered flags N=0 Z=1 C=1 V=0
    drive(1, 4'b0110, 0, BR_B, EQ, 0, 0);
    drive(0, 4'b0000, 1, BR_COND, EQ, 0, 0);
    drive(0, 4'b0000, 1, BR_COND, NE, 0, 0);
    // bypass
    drive(1, 4'b0000, 0, BR_B, EQ, 0, 0);
    drive(1, 4'b0100, 1, BR_COND, EQ, 0, 0);
    // signed compares
    drive(1, 4'b1000, 0, BR_B, EQ, 0, 0);
    drive(0, 4'b0000, 1, BR_COND, LT, 0, 0);
    drive(0, 4'b0000, 1, BR_COND, GE, 0, 0);
    drive(1, 4'b1001, 0, BR_B, EQ, 0, 0);
    drive(0, 4'b0000, 1, BR_COND, GT, 0, 0);
    drive(0, 4'b0000, 1, BR_COND, LE, 0, 0);
    drive(0, 4'b0000, 1, BR_COND, AL, 0, 0);
    drive(0, 4'b0000, 1, BR_COND, NV, 0, 0);
    // CBZ/CBNZ with registered Z=0 and Z=1
    drive(0, 4'b0100, 1, BR_CBZ, EQ, 0, 0);
    drive(0, 4'b0000, 1, BR_CBZ, EQ, 0, 0);
    drive(0, 4'b0000, 1, BR_CBNZ, EQ, 0, 0);
    drive(1, 4'b0100, 0, BR_B, EQ, 0, 0);
    drive(0, 4'b0000, 1, BR_CBZ, EQ, 0, 0);
    drive(0, 4'b0100, 1, BR_CBNZ, EQ, 0, 0);
    // stall holds a taken EQ for three cycles, then flush squashes a flag write
    drive(0, 4'b0000, 1, BR_COND, EQ, 0, 0);
    for (int i = 0; i < 3; i++) drive(1, 4'b1011, 1, BR_CBNZ, NE, 1, i == 1);
    drive(1, 4'b1011, 1, BR_B, EQ, 0, 1);
    drive(0, 4'b0000, 1, BR_COND, EQ, 0, 0);
    for (int i = 0; i < 400; i++)
      drive($urandom_range(0, 1), 4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0,
            2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
            $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
    // async reset mid-cycle from flags=1111, br_valid=1
    drive(1, 4'b1111, 1, BR_B, EQ, 0, 0);
    @(posedge clk);
    #3;
    check("pre_reset", {bus.flags, bus.br_valid, bus.br_taken}, 6'b111111);
    reset = 1'b1;
    #1;
    check("async_reset", {bus.flags, bus.br_valid, bus.br_taken}, 6'b0);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/flag_branch_unit.md
# flag_branch_unit

Consumer end of the 64-bit ALU's flag outputs. It holds the architectural NZCV flag register, written by flag-setting instructions (ADDS, SUBS, ANDS). It evaluates LEGv8 branch conditions (B, B.cond, CBZ, CBNZ) against the flags or the live ALU zero flag. It delivers a registered taken/not-taken decision to the fetch/PC logic one cycle after each request.

## Interface
Parameters:
- none (fixed 4-bit condition field, 2-bit branch type)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clears all state
- alu_negative  input  1  ALU negative flag, current cycle
- alu_zero  input  1  ALU zero flag, current cycle
- alu_overflow  input  1  ALU overflow flag, current cycle
- alu_carry_out  input  1  ALU carry-out flag, current cycle
- set_flags  input  1  latch the four ALU flags into the flag register at this edge
- br_req  input  1  a branch is presented for evaluation this cycle
- br_type  input  2  00 B, 01 B.cond, 10 CBZ, 11 CBNZ
- cond  input  4  B.cond condition code; ignored for other types
- stall  input  1  hold every register this edge
- flush  input  1  squash the instruction currently presented
- flags  output  4  registered {N,Z,C,V}
- br_valid  output  1  registered; a decision is on br_taken
- br_taken  output  1  registered; branch taken (meaningful only when br_valid=1)

## Operation
- Flag register: on an edge with set_flags=1, stall=0, flush=0, flags <= {alu_negative, alu_zero, alu_carry_out, alu_overflow}. Otherwise it holds.
- Effective flags for B.cond: if set_flags=1 in the same cycle as br_req (and not stalled/flushed), the live ALU flags are used (bypass). Otherwise the registered flags are used.
- Decision per br_type:
  - B: taken = 1.
  - CBZ: taken = alu_zero. The ALU is in pass-B mode carrying Rt.
  - CBNZ: taken = ~alu_zero.
- cond encoding (N,Z,C,V = effective flags):
  - 0000 EQ: Z
  - 0001 NE: ~Z
  - 0010 HS: C
  - 0011 LO: ~C
  - 0100 MI: N
  - 0101 PL: ~N
  - 0110 VS: V
  - 0111 VC: ~V
  - 1000 HI: C & ~Z
  - 1001 LS: ~(C & ~Z)
  - 1010 GE: N==V
  - 1011 LT: N!=V
  - 1100 GT: ~Z & (N==V)
  - 1101 LE: ~(~Z & (N==V))
  - 1110 AL: 1
  - 1111 NV: 1
- Output register, evaluated in priority order at each edge:
  1. stall=1: br_valid, br_taken and flags all hold.
  2. flush=1: br_valid <= 0, br_taken <= 0; flags do not update.
  3. Otherwise: br_valid <= br_req; br_taken <= br_req & decision.
- br_taken is forced 0 whenever br_valid is 0. There are no X-propagating don't-cares.

## Timing
- Reset (asynchronous, immediate): flags=0000, br_valid=0, br_taken=0. Reset dominates stall and flush.
- Latency: br_req in cycle n produces br_valid/br_taken in cycle n+1. The result is held for exactly one cycle unless stall=1, in which case it holds until stall drops.
- Flag write latency: set_flags in cycle n makes flags visible on the output in cycle n+1. The bypass makes the new flags usable by a B.cond in cycle n itself.
- Back-to-back br_req every cycle is supported. Throughput is 1 decision per cycle.
- Simultaneous stall and flush: stall wins, and the flush is lost.
  - The pipeline controller must hold flush until stall deasserts.
- Reset released mid-sequence: the first edge after deassertion behaves as a normal cycle.

## Structure
- Shared package branch_pkg holds:
  - the cond_t enum (EQ..NV, 4-bit);
  - the br_type_t enum (BR_B, BR_COND, BR_CBZ, BR_CBNZ);
  - the flag bit-index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- One sub-module, cond_eval: purely combinational. It maps cond plus {N,Z,C,V} to a pass bit. It is unit-testable exhaustively (16×16 cases).
- The top level contains the flag register, the bypass mux, the br_type mux and the output register.

## Test plan
- Reset: assert reset mid-cycle with flags=1111 and br_valid=1 -> flags=0000, br_valid=0, br_taken=0 immediately, without waiting for a clock edge.
- Flag write and B.cond:
  - set_flags with ALU N=0, Z=1, C=1, V=0, then br_req B.cond EQ next cycle -> br_valid=1, br_taken=1.
  - Same flags with cond NE -> br_taken=0.
- Bypass: registered flags=0000; the same cycle carries set_flags=1 with alu_zero=1 and br_req B.cond EQ -> br_taken=1 next cycle. flags=0100 also next cycle.
- Signed compares: flags N=1, V=0 -> LT taken, GE not taken. Flags N=1, V=1, Z=0 -> GT taken, LE not taken. AL and NV are always taken.
- CBZ/CBNZ: alu_zero=1 with CBZ -> taken; alu_zero=0 with CBZ -> not taken; alu_zero=0 with CBNZ -> taken. Registered flags have no effect in any of these cases.
- Stall and flush:
  - br_req EQ taken, then stall for 3 cycles -> br_valid=1, br_taken=1 held for all 3 cycles.
  - flush with br_req=1 and set_flags=1 -> br_valid=0 next cycle and flags unchanged.
